// File: rtl/pc_fetch_gen.sv
// Program counter and instruction-fetch request stage. Holds at most one icache request
// outstanding and discards responses that belong to the wrong path after a redirect.
module pc_fetch_gen #(
    parameter int                ADDR_W   = 64,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h8000_0000,
    parameter int                PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        ctrl_signal_pc_i,
    input  logic [ADDR_W-1:0] ctrl_pc_new_i,
    output logic              icache_req_valid_o,
    output logic [ADDR_W-1:0] icache_req_addr_o,
    input  logic              icache_req_ready_i,
    input  logic              icache_data_valid_i,
    input  logic [INST_W-1:0] icache_data_i,
    output logic              if_valid_o,
    output logic [ADDR_W-1:0] if_pc_o,
    output logic [INST_W-1:0] if_inst_o,
    output logic              pc_misalign_o,
    output logic [1:0]        dbg_state
);

    // Handshake: a request transfers on a cycle where icache_req_valid_o && icache_req_ready_i;
    // valid and address then hold until that cycle. Each accepted request yields exactly one
    // icache_data_valid_i pulse; if_valid_o is a single-cycle strobe with no back-pressure.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        KILL = 2'd3
    } state_t;

    localparam logic [1:0] CODE_BRANCH = 2'b01;
    localparam logic [1:0] CODE_STALL  = 2'b11;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic [ADDR_W-1:0] redir_tgt, redir_tgt_nxt;
    logic              redir_pend, redir_pend_nxt;

    logic              is_branch;
    logic              is_stall;
    logic [ADDR_W-1:0] target;
    logic              deliver;

    assign is_branch = (ctrl_signal_pc_i == CODE_BRANCH);
    assign is_stall  = (ctrl_signal_pc_i == CODE_STALL);
    assign target    = {ctrl_pc_new_i[ADDR_W-1:2], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            redir_tgt  <= '0;
            redir_pend <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            redir_tgt  <= redir_tgt_nxt;
            redir_pend <= redir_pend_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        redir_tgt_nxt  = redir_tgt;
        redir_pend_nxt = redir_pend;
        case (state)
            IDLE: begin
                if (is_branch) pc_nxt = target;
                if (!is_stall) state_nxt = REQ;
            end
            REQ: begin
                if (icache_req_ready_i) begin
                    state_nxt      = (is_branch || redir_pend) ? KILL : WAIT;
                    redir_pend_nxt = 1'b0;
                    if (is_branch)       pc_nxt = target;
                    else if (redir_pend) pc_nxt = redir_tgt;
                end else if (is_branch) begin
                    // The offered address must stay put, so park the target until acceptance.
                    redir_pend_nxt = 1'b1;
                    redir_tgt_nxt  = target;
                end
            end
            WAIT: begin
                if (icache_data_valid_i) begin
                    if (is_branch) begin
                        pc_nxt    = target;
                        state_nxt = REQ;
                    end else begin
                        pc_nxt    = pc + ADDR_W'(PC_STEP);
                        state_nxt = is_stall ? IDLE : REQ;
                    end
                end else if (is_branch) begin
                    pc_nxt    = target;
                    state_nxt = KILL;
                end
            end
            KILL: begin
                if (is_branch) pc_nxt = target;
                if (icache_data_valid_i) state_nxt = is_stall ? IDLE : REQ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        deliver            = (state == WAIT) && icache_data_valid_i && !is_branch;
        icache_req_valid_o = (state == REQ);
        icache_req_addr_o  = pc;
        if_valid_o         = deliver;
        if_pc_o            = deliver ? pc : '0;
        if_inst_o          = deliver ? icache_data_i : '0;
        pc_misalign_o      = is_branch && (ctrl_pc_new_i[1:0] != 2'b00) && !rst;
        dbg_state          = state;
    end

endmodule
